// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
// Module   : if_stage
// Purpose  : Instruction-fetch stage. Holds the PC, issues fetch requests to
//            an instruction memory with a ready handshake, and registers the
//            fetched instruction into the IF/ID pipeline register. A one-entry
//            skid buffer catches a response that lands during a load-use
//            stall. A DROP state swallows the response of a request that a
//            taken branch or jump has made stale.
// Ports    : Clk         - clock; state changes on the falling edge
//            Rst         - asynchronous active-high reset
//            bubble      - load-use stall: hold the PC and IF/ID
//            MEM_PCSrc   - taken branch/jump in MEM: redirect and flush
//            MEM_Target  - redirect address
//            imem_req    - fetch request valid
//            imem_addr   - fetch address, held until imem_ready
//            imem_ready  - response valid; completes the request
//            imem_rdata  - instruction word returned by memory
//            ID_PC4      - PC+4 of the instruction in ID
//            ID_Instr    - instruction in ID (32'h0 is a NOP)
//            ID_valid    - ID_Instr holds a real instruction
//            IF_wait     - fetch is stalled waiting on memory
// Revision : 1.0 - initial release
// ============================================================================
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        bubble,
    input  logic        MEM_PCSrc,
    input  logic [31:0] MEM_Target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ID_PC4,
    output logic [31:0] ID_Instr,
    output logic        ID_valid,
    output logic        IF_wait
);

    localparam logic [1:0] S_FETCH = 2'd0;
    localparam logic [1:0] S_HOLD  = 2'd1;
    localparam logic [1:0] S_DROP  = 2'd2;

    localparam logic [31:0] C_RESET_PC = RESET_PC & 32'hFFFF_FFFC;

    logic [1:0]  state_q,      state_d;
    logic [31:0] pc_q,         pc_d;
    logic [31:0] req_addr_q,   req_addr_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [31:0] skid_pc4_q,   skid_pc4_d;
    logic [31:0] id_pc4_q,     id_pc4_d;
    logic [31:0] id_instr_q,   id_instr_d;
    logic        id_valid_q,   id_valid_d;

    logic [31:0] w_pc4;
    logic [31:0] w_target;

    // PC+4 wraps naturally in 32 bits; every loaded address is word aligned.
    assign w_pc4    = pc_q + 32'd4;
    assign w_target = MEM_Target & 32'hFFFF_FFFC;

    assign imem_req  = !Rst && (state_q != S_HOLD);
    assign imem_addr = req_addr_q;
    assign IF_wait   = (state_q == S_FETCH) && imem_req && !imem_ready;

    assign ID_PC4   = id_pc4_q;
    assign ID_Instr = id_instr_q;
    assign ID_valid = id_valid_q;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        req_addr_d   = req_addr_q;
        skid_instr_d = skid_instr_q;
        skid_pc4_d   = skid_pc4_q;
        id_pc4_d     = id_pc4_q;
        id_instr_d   = id_instr_q;
        id_valid_d   = id_valid_q;

        if (MEM_PCSrc) begin
            // Redirect outranks a stall: flush IF/ID and the skid buffer.
            id_pc4_d     = 32'h0;
            id_instr_d   = 32'h0;
            id_valid_d   = 1'b0;
            pc_d         = w_target;
            skid_instr_d = 32'h0;
            skid_pc4_d   = 32'h0;
            case (state_q)
                S_FETCH: begin
                    if (imem_ready) begin
                        // Response completes now and is simply not used.
                        req_addr_d = w_target;
                    end else begin
                        // Request still in flight; let it finish in DROP.
                        state_d = S_DROP;
                    end
                end
                S_HOLD: begin
                    state_d    = S_FETCH;
                    req_addr_d = w_target;
                end
                S_DROP:  state_d = S_DROP;
                default: begin
                    state_d    = S_FETCH;
                    req_addr_d = w_target;
                end
            endcase
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (imem_ready) begin
                        pc_d = w_pc4;
                        if (bubble) begin
                            // ID cannot take it; park the word in the skid.
                            skid_instr_d = imem_rdata;
                            skid_pc4_d   = w_pc4;
                            state_d      = S_HOLD;
                        end else begin
                            id_pc4_d   = w_pc4;
                            id_instr_d = imem_rdata;
                            id_valid_d = 1'b1;
                            req_addr_d = w_pc4;
                        end
                    end else if (!bubble) begin
                        id_pc4_d   = 32'h0;
                        id_instr_d = 32'h0;
                        id_valid_d = 1'b0;
                    end
                end
                S_HOLD: begin
                    if (!bubble) begin
                        id_pc4_d   = skid_pc4_q;
                        id_instr_d = skid_instr_q;
                        id_valid_d = 1'b1;
                        req_addr_d = pc_q;
                        state_d    = S_FETCH;
                    end
                end
                S_DROP: begin
                    // Stale response is consumed here and never stored.
                    if (!bubble) begin
                        id_pc4_d   = 32'h0;
                        id_instr_d = 32'h0;
                        id_valid_d = 1'b0;
                    end
                    if (imem_ready) begin
                        req_addr_d = pc_q;
                        state_d    = S_FETCH;
                    end
                end
                default: begin
                    req_addr_d = pc_q;
                    state_d    = S_FETCH;
                end
            endcase
        end
    end

    always_ff @(negedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q      <= S_FETCH;
            pc_q         <= C_RESET_PC;
            req_addr_q   <= C_RESET_PC;
            skid_instr_q <= 32'h0;
            skid_pc4_q   <= 32'h0;
            id_pc4_q     <= 32'h0;
            id_instr_q   <= 32'h0;
            id_valid_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            req_addr_q   <= req_addr_d;
            skid_instr_q <= skid_instr_d;
            skid_pc4_q   <= skid_pc4_d;
            id_pc4_q     <= id_pc4_d;
            id_instr_q   <= id_instr_d;
            id_valid_q   <= id_valid_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_stage
// Purpose  : Self-checking bench for if_stage. The instruction memory model
//            answers every address A with the word A+1, so each fetched word
//            identifies the address it came from.
// Revision : 1.0 - initial release
// ============================================================================
module tb_if_stage;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        bubble;
    logic        MEM_PCSrc;
    logic [31:0] MEM_Target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] ID_PC4;
    logic [31:0] ID_Instr;
    logic        ID_valid;
    logic        IF_wait;

    typedef struct packed {
        logic [31:0] pc4;
        logic [31:0] instr;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   tests = 0;
    int   fails = 0;

    assign imem_rdata = imem_addr + 32'd1;

    always #5 Clk = ~Clk;

    if_stage #(.RESET_PC(32'h0000_0000)) dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .bubble     (bubble),
        .MEM_PCSrc  (MEM_PCSrc),
        .MEM_Target (MEM_Target),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rdata (imem_rdata),
        .ID_PC4     (ID_PC4),
        .ID_Instr   (ID_Instr),
        .ID_valid   (ID_valid),
        .IF_wait    (IF_wait)
    );

    // Advance past one active (falling) edge and settle.
    task automatic step();
        @(negedge Clk);
        #1;
    endtask

    task automatic test_reset();
        Rst = 1'b1; bubble = 1'b0; MEM_PCSrc = 1'b0;
        MEM_Target = 32'h0; imem_ready = 1'b0;
        step();
        tests++;
        if (imem_req !== 1'b0) begin
            fails++; $display("FAIL reset_req: got %b want 0", imem_req);
        end
        tests++;
        if (imem_addr !== 32'h0) begin
            fails++; $display("FAIL reset_addr: got %h want 00000000", imem_addr);
        end
        tests++;
        if (ID_valid !== 1'b0 || ID_Instr !== 32'h0 || ID_PC4 !== 32'h0) begin
            fails++; $display("FAIL reset_ifid: got v=%b i=%h p=%h want 0/0/0", ID_valid, ID_Instr, ID_PC4);
        end
        Rst = 1'b0;
        #1;
        tests++;
        if (imem_req !== 1'b1 || IF_wait !== 1'b1) begin
            fails++; $display("FAIL release_req: got req=%b wait=%b want 1/1", imem_req, IF_wait);
        end
    endtask

    // Stream from address 0: addresses 0,4,8 deliver words 1,5,9.
    task automatic test_stream();
        imem_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            sb.push_back('{pc4: 32'(4*k + 4), instr: 32'(4*k + 1)});
            tests++;
            if (imem_addr !== 32'(4*k)) begin
                fails++; $display("FAIL stream_addr%0d: got %h want %h", k, imem_addr, 32'(4*k));
            end
            step();
            e = sb.pop_front();
            tests++;
            if (ID_valid !== 1'b1 || ID_Instr !== e.instr || ID_PC4 !== e.pc4) begin
                fails++; $display("FAIL stream_out%0d: got v=%b i=%h p=%h want 1/%h/%h", k, ID_valid, ID_Instr, ID_PC4, e.instr, e.pc4);
            end
        end
    endtask

    // Two-cycle stall while the word at 12 arrives; it must come out once.
    task automatic test_bubble();
        bubble = 1'b1; imem_ready = 1'b1;
        sb.push_back('{pc4: 32'd16, instr: 32'd13});
        for (int k = 0; k < 2; k++) begin
            step();
            tests++;
            if (ID_Instr !== 32'd9 || ID_valid !== 1'b1 || imem_req !== 1'b0) begin
                fails++; $display("FAIL bubble_hold%0d: got i=%h v=%b req=%b want 9/1/0", k, ID_Instr, ID_valid, imem_req);
            end
        end
        bubble = 1'b0;
        step();
        e = sb.pop_front();
        tests++;
        if (ID_valid !== 1'b1 || ID_Instr !== e.instr || ID_PC4 !== e.pc4) begin
            fails++; $display("FAIL bubble_release: got v=%b i=%h p=%h want 1/%h/%h", ID_valid, ID_Instr, ID_PC4, e.instr, e.pc4);
        end
        tests++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin
            fails++; $display("FAIL bubble_next: got req=%b addr=%h want 1/00000010", imem_req, imem_addr);
        end
    endtask

    // Memory holds off for three cycles at 0x10.
    task automatic test_wait();
        imem_ready = 1'b0;
        sb.push_back('{pc4: 32'h14, instr: 32'h11});
        for (int k = 0; k < 3; k++) begin
            #1;
            tests++;
            if (IF_wait !== 1'b1 || imem_addr !== 32'h10) begin
                fails++; $display("FAIL wait_stall%0d: got wait=%b addr=%h want 1/00000010", k, IF_wait, imem_addr);
            end
            step();
            tests++;
            if (ID_valid !== 1'b0 || ID_Instr !== 32'h0) begin
                fails++; $display("FAIL wait_nop%0d: got v=%b i=%h want 0/0", k, ID_valid, ID_Instr);
            end
        end
        imem_ready = 1'b1;
        step();
        e = sb.pop_front();
        tests++;
        if (ID_valid !== 1'b1 || ID_Instr !== e.instr || ID_PC4 !== e.pc4) begin
            fails++; $display("FAIL wait_deliver: got v=%b i=%h p=%h want 1/%h/%h", ID_valid, ID_Instr, ID_PC4, e.instr, e.pc4);
        end
    endtask

    // Stream up to 0x40, stall it, redirect to 0x203 while outstanding.
    task automatic test_redirect_drop();
        imem_ready = 1'b1;
        for (int k = 0; k < 11; k++) begin
            sb.push_back('{pc4: 32'(32'h18 + 4*k), instr: 32'(32'h15 + 4*k)});
            step();
            e = sb.pop_front();
            tests++;
            if (ID_Instr !== e.instr || ID_PC4 !== e.pc4) begin
                fails++; $display("FAIL run_out%0d: got i=%h p=%h want %h/%h", k, ID_Instr, ID_PC4, e.instr, e.pc4);
            end
        end
        imem_ready = 1'b0;
        step();
        tests++;
        if (imem_addr !== 32'h40 || IF_wait !== 1'b1) begin
            fails++; $display("FAIL drop_pending: got addr=%h wait=%b want 00000040/1", imem_addr, IF_wait);
        end
        MEM_PCSrc = 1'b1; MEM_Target = 32'h203;
        step();
        MEM_PCSrc = 1'b0; MEM_Target = 32'h0;
        #1;
        tests++;
        if (ID_valid !== 1'b0 || ID_Instr !== 32'h0 || ID_PC4 !== 32'h0) begin
            fails++; $display("FAIL drop_flush: got v=%b i=%h p=%h want 0/0/0", ID_valid, ID_Instr, ID_PC4);
        end
        tests++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h40 || IF_wait !== 1'b0) begin
            fails++; $display("FAIL drop_state: got req=%b addr=%h wait=%b want 1/00000040/0", imem_req, imem_addr, IF_wait);
        end
        imem_ready = 1'b1;
        step();
        tests++;
        if (ID_valid !== 1'b0 || ID_Instr !== 32'h0 || imem_addr !== 32'h200) begin
            fails++; $display("FAIL drop_discard: got v=%b i=%h addr=%h want 0/0/00000200", ID_valid, ID_Instr, imem_addr);
        end
        sb.push_back('{pc4: 32'h204, instr: 32'h201});
        step();
        e = sb.pop_front();
        tests++;
        if (ID_valid !== 1'b1 || ID_Instr !== e.instr || ID_PC4 !== e.pc4) begin
            fails++; $display("FAIL drop_target: got v=%b i=%h p=%h want 1/%h/%h", ID_valid, ID_Instr, ID_PC4, e.instr, e.pc4);
        end
    endtask

    // Redirect with bubble while HOLD owns a skid word; then PC wrap.
    task automatic test_redirect_hold_wrap();
        bubble = 1'b1; imem_ready = 1'b1;
        step();
        tests++;
        if (imem_req !== 1'b0 || ID_Instr !== 32'h201) begin
            fails++; $display("FAIL hold_enter: got req=%b i=%h want 0/00000201", imem_req, ID_Instr);
        end
        MEM_PCSrc = 1'b1; MEM_Target = 32'hFFFF_FFFC;
        step();
        MEM_PCSrc = 1'b0; MEM_Target = 32'h0; bubble = 1'b0;
        #1;
        tests++;
        if (ID_valid !== 1'b0 || ID_Instr !== 32'h0 || imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin
            fails++; $display("FAIL hold_redirect: got v=%b i=%h req=%b addr=%h want 0/0/1/fffffffc", ID_valid, ID_Instr, imem_req, imem_addr);
        end
        sb.push_back('{pc4: 32'h0, instr: 32'hFFFF_FFFD});
        sb.push_back('{pc4: 32'h4, instr: 32'h1});
        for (int k = 0; k < 2; k++) begin
            step();
            e = sb.pop_front();
            tests++;
            if (ID_valid !== 1'b1 || ID_Instr !== e.instr || ID_PC4 !== e.pc4) begin
                fails++; $display("FAIL wrap_out%0d: got v=%b i=%h p=%h want 1/%h/%h", k, ID_valid, ID_Instr, ID_PC4, e.instr, e.pc4);
            end
            tests++;
            if (imem_addr !== 32'(4*k + 4) - 32'd4) begin
                fails++; $display("FAIL wrap_addr%0d: got %h want %h", k, imem_addr, 32'(4*k));
            end
        end
    endtask

    // Reset asserted between edges while a request is outstanding.
    task automatic test_reset_mid();
        imem_ready = 1'b0;
        step();
        #2;
        Rst = 1'b1;
        #1;
        tests++;
        if (imem_req !== 1'b0 || imem_addr !== 32'h0 || ID_valid !== 1'b0 || ID_Instr !== 32'h0) begin
            fails++; $display("FAIL reset_async: got req=%b addr=%h v=%b i=%h want 0/0/0/0", imem_req, imem_addr, ID_valid, ID_Instr);
        end
        step();
        Rst = 1'b0;
        imem_ready = 1'b1;
        #1;
        tests++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            fails++; $display("FAIL reset_refetch: got req=%b addr=%h want 1/0", imem_req, imem_addr);
        end
        sb.push_back('{pc4: 32'h4, instr: 32'h1});
        step();
        e = sb.pop_front();
        tests++;
        if (ID_valid !== 1'b1 || ID_Instr !== e.instr || ID_PC4 !== e.pc4) begin
            fails++; $display("FAIL reset_first: got v=%b i=%h p=%h want 1/%h/%h", ID_valid, ID_Instr, ID_PC4, e.instr, e.pc4);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_bubble();
        test_wait();
        test_redirect_drop();
        test_redirect_hold_wrap();
        test_reset_mid();
        tests++;
        if (sb.size() != 0) begin
            fails++; $display("FAIL scoreboard_empty: got %0d entries want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
